// File: rtl/spm_serial_mult.sv
// spm_serial_mult: serial-parallel multiplier built on a chain of carry-save cells.
//
// The WIDTH-bit multiplicand x is held in parallel across WIDTH cells. The multiplier y is
// fed through the chain one bit per cycle, LSB first, for 2*WIDTH cycles. Cell 0 yields
// one product bit per cycle. The bits are emitted serially on p/p_valid and are also
// assembled into the parallel product register.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   start    in   one-cycle request, accepted only while busy = 0
//   x        in   WIDTH     multiplicand, sampled on accept
//   y        in   WIDTH     multiplier, sampled on accept
//   busy     out  high while an operation is in flight
//   p        out  serial product bit, LSB first
//   p_valid  out  qualifies p
//   done     out  one-cycle pulse alongside the final product bit
//   product  out  2*WIDTH   parallel product, loaded in the done cycle and held otherwise
//
// Build option:
//   SPM_SIGNED_EN  When defined, x and y are treated as two's complement.
//                  When undefined (the default), both operands are unsigned.
module spm_serial_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               p,
    output logic               p_valid,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(PW);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PW - 1);
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(PW - 2);

    typedef enum logic {StIdle, StRun} state_e;

    state_e r_state, w_state_d;

    logic [WIDTH-1:0] r_x;      // multiplicand
    logic [WIDTH-1:0] r_y;      // remaining multiplier bits; bit 0 is the next serial bit
    logic [WIDTH-1:0] r_s;      // cell sum flops
    logic [WIDTH-1:0] r_c;      // cell carry flops (the top cell holds a borrow when signed)
    logic [CNT_W-1:0] r_cnt;    // index of the product bit currently on p
    logic [PW-1:0]    r_psr;    // product shift register, filled from the MSB end
    logic [PW-1:0]    r_product;
    logic             r_p;
    logic             r_p_valid;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_step;
    logic [WIDTH-1:0] w_x_cur;
    logic [WIDTH-1:0] w_s_cur;
    logic [WIDTH-1:0] w_c_cur;
    logic             w_ybit;
    logic             w_y_fill;
    logic [WIDTH-1:0] w_y_src;
    logic [WIDTH-1:0] w_sum_in;
    logic [WIDTH-1:0] w_pp;
    logic [WIDTH-1:0] w_hsum;
    logic [WIDTH-1:0] w_cout;

    assign w_accept = (r_state == StIdle) && start;
    assign w_last   = (r_state == StRun) && (r_cnt == LAST);
    // A new product bit is computed on accept (bit 0) and on every RUN cycle but the last.
    assign w_step   = w_accept || ((r_state == StRun) && !w_last);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (start)  w_state_d = StRun;
            StRun:   if (w_last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // CSA cell chain
    // ------------------------------------------------------------------
    // On accept, the cells see cleared state and the freshly presented operands. This lets
    // bit 0 be computed in the accept cycle so that it appears on p one cycle later.
    assign w_x_cur = w_accept ? x    : r_x;
    assign w_s_cur = w_accept ? '0   : r_s;
    assign w_c_cur = w_accept ? '0   : r_c;
    assign w_ybit  = w_accept ? y[0] : r_y[0];
    assign w_y_src = w_accept ? y    : r_y;

`ifdef SPM_SIGNED_EN
    // Sign-extend the multiplier beyond its top bit.
    assign w_y_fill = w_y_src[WIDTH-1];
`else
    assign w_y_fill = 1'b0;
`endif

    always_comb begin
        // Each cell takes the sum of its upper neighbour. Nothing feeds the top cell from
        // above: every weight is already held inside the chain, including the top borrow.
        w_sum_in = {1'b0, w_s_cur[WIDTH-1:1]};
        w_pp     = w_x_cur & {WIDTH{w_ybit}};
        w_hsum   = w_pp ^ w_sum_in ^ w_c_cur;
        w_cout   = (w_pp & w_sum_in) | (w_pp & w_c_cur) | (w_sum_in & w_c_cur);
`ifdef SPM_SIGNED_EN
        // x[WIDTH-1] carries negative weight, so the top cell is a full subtractor:
        // sum_in - pp - borrow. Its difference bit equals the adder's sum bit, and its
        // carry flop holds a borrow instead.
        w_cout[WIDTH-1] = (~w_sum_in[WIDTH-1] & (w_pp[WIDTH-1] | w_c_cur[WIDTH-1]))
                        | (w_pp[WIDTH-1] & w_c_cur[WIDTH-1]);
`endif
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_s       <= '0;
            r_c       <= '0;
            r_cnt     <= '0;
            r_psr     <= '0;
            r_product <= '0;
            r_p       <= 1'b0;
            r_p_valid <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_step) begin
            r_s       <= w_hsum;
            r_c       <= w_cout;
            r_y       <= {w_y_fill, w_y_src[WIDTH-1:1]};
            r_p       <= w_hsum[0];
            r_p_valid <= 1'b1;
            if (w_accept) begin
                r_x    <= x;
                r_cnt  <= '0;
                r_psr  <= {w_hsum[0], {(PW-1){1'b0}}};
                r_done <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_psr  <= {w_hsum[0], r_psr[PW-1:1]};
                r_done <= (r_cnt == LAST_M1);
                if (r_cnt == LAST_M1) begin
                    r_product <= {w_hsum[0], r_psr[PW-1:1]};
                end
            end
        end else if (w_last) begin
            r_p       <= 1'b0;
            r_p_valid <= 1'b0;
            r_done    <= 1'b0;
        end
    end

    assign busy    = (r_state == StRun);
    assign p       = r_p;
    assign p_valid = r_p_valid;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_spm_serial_mult.sv
// Directed bench for spm_serial_mult (WIDTH = 8). Expected products are hand-computed,
// and the signed or unsigned values are chosen by SPM_SIGNED_EN.
module tb_spm_serial_mult;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          busy;
    logic          p;
    logic          p_valid;
    logic          done;
    logic [PW-1:0] product;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spm_serial_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .p       (p),
        .p_valid (p_valid),
        .done    (done),
        .product (product)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one operation, then check every cycle of it. When chg_cyc is nonzero, the
    // operand inputs are zeroed in that cycle.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                          input logic [PW-1:0] exp, input string tag, input int chg_cyc);
        logic [PW-1:0] ser;
        @(negedge clk);
        x = xa;
        y = ya;
        start = 1'b1;
        @(negedge clk);          // cycle 1
        start = 1'b0;
        ser = '0;
        for (int k = 0; k < PW; k++) begin
            if (k + 1 == chg_cyc) begin
                x = '0;
                y = '0;
            end
            chk1({tag, " p_valid"}, p_valid, 1'b1);
            chk1({tag, " busy"}, busy, 1'b1);
            chk1({tag, " done"}, done, (k == PW - 1));
            ser[k] = p;
            if (k == PW - 1) chkp({tag, " product"}, product, exp);
            @(negedge clk);
        end
        chkp({tag, " serial"}, ser, exp);
        chk1({tag, " busy_end"}, busy, 1'b0);
        chk1({tag, " p_valid_end"}, p_valid, 1'b0);
        chk1({tag, " done_end"}, done, 1'b0);
        chkp({tag, " product_held"}, product, exp);
    endtask

    initial begin
        logic [PW-1:0] exp_neg;
        logic [PW-1:0] exp_ff;
`ifdef SPM_SIGNED_EN
        exp_neg = 16'hC080;
        exp_ff  = 16'h0001;
`else
        exp_neg = 16'h3F80;
        exp_ff  = 16'hFE01;
`endif
        // Reset state
        #12;
        chk1("rst busy", busy, 1'b0);
        chk1("rst p", p, 1'b0);
        chk1("rst p_valid", p_valid, 1'b0);
        chk1("rst done", done, 1'b0);
        chkp("rst product", product, '0);
        @(negedge clk);
        rst = 1'b1;

        run_op(8'd3, 8'd5, 16'h000F, "x3y5", 0);
        run_op(8'h80, 8'h7F, exp_neg, "x80y7f", 0);
        run_op(8'hFF, 8'hFF, exp_ff, "xffyff", 0);
        run_op(8'd7, 8'd9, 16'h003F, "chg_xy", 5);

        // start held high: accepts happen in cycle 0 and cycle 17 only
        @(negedge clk);
        x = 8'd2;
        y = 8'd3;
        start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            chk1("held busy", busy, (c != 17 && c != 34));
            chk1("held p_valid", p_valid, (c != 17 && c != 34));
            chk1("held done", done, (c == 16 || c == 33));
            if (c == 16 || c == 33) chkp("held product", product, 16'h0006);
        end
        start = 1'b0;
        @(negedge clk);
        chk1("held busy_after", busy, 1'b0);
        chk1("held done_after", done, 1'b0);

        // Reset mid-operation
        @(negedge clk);
        x = 8'd7;
        y = 8'd9;
        start = 1'b1;
        @(negedge clk);          // cycle 1
        start = 1'b0;
        repeat (4) @(negedge clk);  // cycle 5
        chk1("pre_rst busy", busy, 1'b1);
        chk1("pre_rst p_valid", p_valid, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;           // inside cycle 6
        #1;
        chk1("async busy", busy, 1'b0);
        chk1("async p", p, 1'b0);
        chk1("async p_valid", p_valid, 1'b0);
        chk1("async done", done, 1'b0);
        chkp("async product", product, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk1("post_rst done", done, 1'b0);
            chk1("post_rst busy", busy, 1'b0);
            chkp("post_rst product", product, '0);
        end
        run_op(8'd2, 8'd2, 16'h0004, "after_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
